// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// The request fields are held stable while dmem_req is high, until dmem_ready.
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: issues one variable-latency data-memory request per
// instruction, stalls the pipeline while it is outstanding, and formats store lanes / load data.
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              MEM_valid,
    input  logic              MEM_memory_read,
    input  logic              MEM_memory_write,
    input  logic [2:0]        MEM_funct3,
    input  logic [XLEN-1:0]   MEM_alu_result,
    input  logic [XLEN-1:0]   MEM_rs2_data,
    mem_access_unit_if.master dmem,
    output logic              mem_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              access_fault
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            flushed_q, flushed_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      lo_q, lo_d;
    logic [2:0]      f3_q, f3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            access, bad_align, bad_width;
    logic [XLEN-1:0] st_wdata, ld_ext;
    logic [3:0]      st_wstrb;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    assign access = MEM_valid & (MEM_memory_read | MEM_memory_write) & ~flush;

    always_comb begin
        bad_align = ((MEM_funct3 == 3'b001 || MEM_funct3 == 3'b101) && MEM_alu_result[0]) ||
                    (MEM_funct3 == 3'b010 && MEM_alu_result[1:0] != 2'b00);
        bad_width = (MEM_funct3 == 3'b011) || (MEM_funct3 == 3'b110) || (MEM_funct3 == 3'b111) ||
                    (MEM_memory_write && (MEM_funct3 == 3'b100 || MEM_funct3 == 3'b101));
    end

    // Store data is replicated into every lane; the strobes pick the byte(s) actually written.
    always_comb begin
        st_wdata = '0;
        st_wstrb = 4'b0000;
        if (MEM_memory_write) begin
            case (MEM_funct3[1:0])
                2'b00: begin
                    st_wdata = {(XLEN/8){MEM_rs2_data[7:0]}};
                    st_wstrb = 4'b0001 << MEM_alu_result[1:0];
                end
                2'b01: begin
                    st_wdata = {(XLEN/16){MEM_rs2_data[15:0]}};
                    st_wstrb = 4'b0011 << MEM_alu_result[1:0];
                end
                default: begin
                    st_wdata = MEM_rs2_data;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Lane select uses the latched low address bits, since the pipeline inputs are frozen but not ours.
    always_comb begin
        rd_byte = dmem.dmem_rdata[{lo_q, 3'b000} +: 8];
        rd_half = dmem.dmem_rdata[{lo_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rd_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rd_half};
            default: ld_ext = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        lo_d        = lo_q;
        f3_d        = f3_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        mem_stall   = 1'b0;
        misaligned  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (bad_align || bad_width) begin
                        misaligned = 1'b1;
                    end else begin
                        req_d     = 1'b1;
                        we_d      = MEM_memory_write;
                        addr_d    = {MEM_alu_result[XLEN-1:2], 2'b00};
                        wdata_d   = st_wdata;
                        wstrb_d   = st_wstrb;
                        lo_d      = MEM_alu_result[1:0];
                        f3_d      = MEM_funct3;
                        cnt_d     = '0;
                        flushed_d = 1'b0;
                        mem_stall = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // A flush cannot abandon the bus transaction; it only discards the result.
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (flush) flushed_d = 1'b1;
                if (dmem.dmem_ready) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (flush || flushed_q) begin
                        state_d = IDLE;
                    end else begin
                        if (!we_q) load_data_d = ld_ext;
                        state_d = DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            lo_q        <= 2'b00;
            f3_q        <= 3'b000;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            lo_q        <= lo_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    assign load_data       = load_data_q;
    assign access_fault    = fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus fields, stall length and load results are
// queued as expectations when each access is driven and checked when the DUT reaches them.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush, MEM_valid, MEM_memory_read, MEM_memory_write;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_result, MEM_rs2_data;
    logic        mem_stall, misaligned, access_fault;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32)) dif ();

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .MEM_valid(MEM_valid), .MEM_memory_read(MEM_memory_read),
        .MEM_memory_write(MEM_memory_write), .MEM_funct3(MEM_funct3),
        .MEM_alu_result(MEM_alu_result), .MEM_rs2_data(MEM_rs2_data),
        .dmem(dif), .mem_stall(mem_stall), .load_data(load_data),
        .misaligned(misaligned), .access_fault(access_fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    bus_t        exp_bus[$];
    int          exp_stall[$];
    logic [31:0] exp_load[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; MEM_valid = 1'b0; MEM_memory_read = 1'b0; MEM_memory_write = 1'b0;
        MEM_funct3 = 3'b000; MEM_alu_result = 32'h0; MEM_rs2_data = 32'h0;
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2);
        MEM_valid = 1'b1; MEM_memory_read = !wr; MEM_memory_write = wr;
        MEM_funct3 = f3; MEM_alu_result = addr; MEM_rs2_data = rs2;
    endtask

    // Called at a negedge with the DUT idle; ready is raised in BUSY cycle busy_n (>= 1).
    task automatic run_access(input string tag, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int busy_n);
        bus_t eb;
        int   stalls;
        drive(wr, f3, addr, rs2);
        stalls = 0;
        for (int c = 0; c <= busy_n; c++) begin
            #1;
            if (mem_stall) stalls++;
            if (c == 1) begin
                eb = exp_bus.pop_front();
                check({tag, "_req"},   32'(dif.dmem_req), 32'd1);
                check({tag, "_addr"},  dif.dmem_addr, eb.addr);
                check({tag, "_we"},    32'(dif.dmem_we), 32'(eb.we));
                check({tag, "_wstrb"}, 32'(dif.dmem_wstrb), 32'(eb.wstrb));
                if (eb.we) check({tag, "_wdata"}, dif.dmem_wdata, eb.wdata);
            end
            if (c == busy_n) begin
                dif.dmem_ready = 1'b1;
                dif.dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        dif.dmem_ready = 1'b0;
        idle_inputs();
        #1;
        check({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
        check({tag, "_done_req"},   32'(dif.dmem_req), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall.pop_front()));
        check({tag, "_load_data"},  load_data, exp_load.pop_front());
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0]  bad_f3[8]   = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001, 3'b100, 3'b011, 3'b110};
    logic        bad_wr[8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] bad_addr[8] = '{32'h101, 32'h103, 32'h001, 32'h202, 32'h001, 32'h100, 32'h100, 32'h100};

    initial begin
        int busy;
        logic seen;
        reset = 1'b1;
        idle_inputs();
        dif.dmem_ready = 1'b0;
        dif.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   32'(dif.dmem_req), 32'd0);
        check("rst_we",    32'(dif.dmem_we), 32'd0);
        check("rst_addr",  dif.dmem_addr, 32'h0);
        check("rst_wdata", dif.dmem_wdata, 32'h0);
        check("rst_wstrb", 32'(dif.dmem_wstrb), 32'd0);
        check("rst_load",  load_data, 32'h0);
        check("rst_fault", 32'(access_fault), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(4); exp_load.push_back(32'hDEADBEEF);
        run_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(2); exp_load.push_back(32'hFFFFFF80);
        run_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(2); exp_load.push_back(32'h00000080);
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1);
        exp_bus.push_back('{32'h200, 1'b1, 32'hABCDABCD, 4'b1100}); exp_stall.push_back(3); exp_load.push_back(32'h00000080);
        run_access("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 2);
        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(2); exp_load.push_back(32'hFFFF8001);
        run_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1);
        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(3); exp_load.push_back(32'h0000F00F);
        run_access("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F00F, 2);
        exp_bus.push_back('{32'h100, 1'b1, 32'hA5A5A5A5, 4'b0010}); exp_stall.push_back(2); exp_load.push_back(32'h0000F00F);
        run_access("sb", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1);
        exp_bus.push_back('{32'h304, 1'b1, 32'hCAFEF00D, 4'b1111}); exp_stall.push_back(2); exp_load.push_back(32'h0000F00F);
        run_access("sw", 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 1);
        exp_bus.push_back('{32'h100, 1'b0, 32'h0, 4'b0000}); exp_stall.push_back(2); exp_load.push_back(32'h0000007F);
        run_access("lb_pos", 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1);

        for (int i = 0; i < 8; i++) begin
            drive(bad_wr[i], bad_f3[i], bad_addr[i], 32'h12345678);
            #1;
            check($sformatf("bad%0d_misaligned", i), 32'(misaligned), 32'd1);
            check($sformatf("bad%0d_stall", i), 32'(mem_stall), 32'd0);
            @(negedge clk); #1;
            check($sformatf("bad%0d_req", i), 32'(dif.dmem_req), 32'd0);
            idle_inputs();
            @(negedge clk);
        end

        drive(1'b0, 3'b010, 32'h100, 32'h0);
        flush = 1'b1;
        #1;
        check("flush_idle_misaligned", 32'(misaligned), 32'd0);
        check("flush_idle_stall", 32'(mem_stall), 32'd0);
        @(negedge clk); #1;
        check("flush_idle_req", 32'(dif.dmem_req), 32'd0);
        idle_inputs();
        @(negedge clk);

        drive(1'b0, 3'b010, 32'h400, 32'h0);
        #1;
        check("to_issue_stall", 32'(mem_stall), 32'd1);
        busy = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk); #1;
            if (access_fault) seen = 1'b1;
            else if (dif.dmem_req) busy++;
        end
        check("to_fault_seen", 32'(seen), 32'd1);
        check("to_busy_cycles", 32'(busy), 32'd64);
        check("to_req_dropped", 32'(dif.dmem_req), 32'd0);
        idle_inputs();
        #1;
        check("to_stall_dropped", 32'(mem_stall), 32'd0);
        check("to_load_unchanged", load_data, 32'h0000007F);
        @(negedge clk); #1;
        check("to_fault_one_cycle", 32'(access_fault), 32'd0);

        drive(1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; MEM_valid = 1'b0;
        #1;
        check("fb_stall_b2", 32'(mem_stall), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fb_req_b3", 32'(dif.dmem_req), 32'd1);
        check("fb_stall_b3", 32'(mem_stall), 32'd1);
        @(negedge clk); #1;
        check("fb_req_b4", 32'(dif.dmem_req), 32'd1);
        dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'h11111111;
        @(negedge clk);
        dif.dmem_ready = 1'b0;
        drive(1'b0, 3'b010, 32'h600, 32'h0);
        #1;
        check("fb_no_done_stall", 32'(mem_stall), 32'd1);
        check("fb_load_unchanged", load_data, 32'h0000007F);
        check("fb_req_dropped", 32'(dif.dmem_req), 32'd0);
        @(negedge clk); #1;
        check("fb_next_req", 32'(dif.dmem_req), 32'd1);
        check("fb_next_addr", dif.dmem_addr, 32'h600);
        dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'h600D600D;
        @(negedge clk);
        dif.dmem_ready = 1'b0;
        idle_inputs();
        #1;
        check("fb_next_done_stall", 32'(mem_stall), 32'd0);
        check("fb_next_load", load_data, 32'h600D600D);
        @(negedge clk);

        dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk); #1;
        check("rdy_idle_load", load_data, 32'h600D600D);
        check("rdy_idle_req", 32'(dif.dmem_req), 32'd0);
        check("rdy_idle_stall", 32'(mem_stall), 32'd0);
        dif.dmem_ready = 1'b0;
        @(negedge clk);

        drive(1'b0, 3'b010, 32'h700, 32'h0);
        @(negedge clk); #1;
        check("rb_req_busy", 32'(dif.dmem_req), 32'd1);
        idle_inputs();
        reset = 1'b1;
        #1;
        check("rb_req_async", 32'(dif.dmem_req), 32'd0);
        check("rb_load_cleared", load_data, 32'h0);
        check("rb_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        check("rb_req_after", 32'(dif.dmem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
